noc_output_arbiter: RTL
=======================

Name: noc_output_arbiter

Overview:
Per-output-port packet arbiter for the 5-port mesh router. It shares one router output link between up to NUM_PORTS input buffers (N/S/E/W/Local). Arbitration is wormhole-style: grant is on a head flit, and the lock is held until the tail flit transfers. Ordering is QoS class first, then round-robin, with an age-based starvation override. One instance sits in front of each router output; it also muxes the granted flit onto the link.

Parameters:
NUM_PORTS, 5, number of requesting input ports (index 0=Local,1=N,2=S,3=E,4=W)
FLIT_W, 288, flit width in bits
AGE_MAX, 15, wait cycles after which a requester is treated as starved (counter width = $clog2(AGE_MAX+1))

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
flit_in  in  NUM_PORTS*FLIT_W  candidate flits, port i at bits [i*FLIT_W +: FLIT_W]
valid_in  in  NUM_PORTS  candidate flit valid
head_in  in  NUM_PORTS  flit i is a packet head
tail_in  in  NUM_PORTS  flit i is a packet tail (head&tail = single-flit packet)
qos_in  in  NUM_PORTS*2  QoS class of port i (qos_level_t, 3=URGENT highest)
ready_out  out  NUM_PORTS  flit i accepted this cycle
flit_out  out  FLIT_W  flit to output link
valid_out  out  1  output flit valid
ready_in  in  1  downstream link ready
grant_onehot  out  NUM_PORTS  current locked grant (0 when idle)
busy  out  1  lock held
packets_granted  out  32  packets granted, wraps at 2^32
starve_grants  out  32  grants won through age override, wraps

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, grant_onehot=0, busy=0, rr_ptr=0, all age counters=0, both 32-bit counters=0.
- Reset outputs: ready_out=0, valid_out=0, flit_out=0.
- Reset asserted mid-packet drops the lock immediately. The rest of the packet is the upstream's problem; no flits are accepted during reset.
- Request i: valid_in[i] && head_in[i].
- Non-head valid flits seen in IDLE are not requests. Their ready_out stays 0.
- FSM IDLE:
  - If any request exists, pick a winner and register it in grant_onehot. Go to LOCKED next cycle and increment packets_granted.
  - Otherwise stay in IDLE.
  - This gives a fixed one-cycle arbitration bubble. No flit transfers in the IDLE cycle.
- Winner selection:
  - (1) Ports with age==AGE_MAX are considered first. If any exist, choose among them and increment starve_grants.
  - (2) Otherwise, choose among requests with the maximum qos_in.
  - Ties in either step go round-robin: the first requester at index >= rr_ptr, wrapping modulo NUM_PORTS.
- FSM LOCKED (grant g):
  - valid_out = valid_in[g].
  - flit_out = flit_in[g] when valid_out, else 0.
  - ready_out[g] = ready_in; every other ready_out = 0.
  - Transfer = valid_out && ready_in.
  - On a transfer with tail_in[g]=1: next state IDLE, rr_ptr = (g+1) mod NUM_PORTS, grant_onehot cleared.
  - Bubbles (valid_in[g]=0) keep the lock.
  - QoS and age changes are ignored while locked.
- Single-flit packet: one LOCKED cycle with transfer, then back to IDLE. Minimum of 2 cycles per packet.
- Age counters:
  - age[i] increments by 1 each cycle that request i is asserted and i is not the port being granted/locked. It saturates at AGE_MAX.
  - age[i] clears on the cycle i wins arbitration, or whenever request i is deasserted.
- Counters are modular, with no saturation.

Decomposition:
- Shared package noc_pkg holds:
  - pkt_type_t, qos_level_t, direction_t
  - port index constants (PORT_LOCAL..PORT_WEST)
  - NOC_FLIT_W=288
- Routers and arbiters import it; the typedefs are not redeclared locally.
- Sub-module noc_rr_pick (NUM_PORTS): combinational. Takes a request vector and rr_ptr and returns a one-hot winner. It is instantiated twice: once for the starved set, once for the top-QoS set.

Test Plan:
- Reset with valid_in=5'b11111 and all heads set -> ready_out=0, valid_out=0, grant_onehot=0 for the whole reset. After release: grant_onehot=5'b00001 one cycle later, packets_granted=1.
- Ports 1 and 3 each send a 3-flit packet at equal QoS=NORMAL, rr_ptr=0, ready_in=1:
  - port 1 wins;
  - flits appear on cycles 2-4;
  - IDLE on cycle 5;
  - port 3 is granted at cycle 6.
- Port 0 QoS=LOW and port 4 QoS=URGENT request together -> port 4 granted first, regardless of rr_ptr.
- Port 2 held at QoS=LOW while ports 0/1 alternate at HIGH with back-to-back single-flit packets:
  - port 2 age reaches 15;
  - port 2 is granted at the next IDLE;
  - starve_grants=1.
- Locked on port 1 mid-packet with ready_in=0 for 4 cycles and valid_in[1] dropped for 2 cycles:
  - no transfer, grant held, ready_out[1]=0;
  - resumes cleanly;
  - the tail returns to IDLE.
- rst pulsed while locked on flit 2 of 4 -> next cycle state IDLE, grant_onehot=0, counters=0, no flit accepted during the reset cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router types and constants: flit width, QoS classes, port/direction
// indices and the output-arbiter state encoding.
package noc_pkg;

  localparam int NOC_FLIT_W    = 288;
  localparam int NOC_NUM_PORTS = 5;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_EAST  = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic [1:0] {
    QOS_LOW    = 2'd0,
    QOS_NORMAL = 2'd1,
    QOS_HIGH   = 2'd2,
    QOS_URGENT = 2'd3
  } qos_level_t;

  typedef enum logic [1:0] {
    PKT_BODY   = 2'd0,
    PKT_HEAD   = 2'd1,
    PKT_TAIL   = 2'd2,
    PKT_SINGLE = 2'd3
  } pkt_type_t;

  typedef enum logic [2:0] {
    DIR_LOCAL = 3'd0,
    DIR_NORTH = 3'd1,
    DIR_SOUTH = 3'd2,
    DIR_EAST  = 3'd3,
    DIR_WEST  = 3'd4
  } direction_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first requester at an
// index >= i_rr_ptr, wrapping back to index 0 when none is found above the pointer.
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_rr_ptr,
  output logic [NUM_PORTS-1:0] o_grant
);

  logic [NUM_PORTS-1:0] w_at_or_above;
  logic [NUM_PORTS-1:0] w_upper;
  logic [NUM_PORTS-1:0] w_pool;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
    assign w_at_or_above[gi] = (PTR_W'(gi) >= i_rr_ptr);
  end

  // Prefer requesters at/above the pointer; otherwise wrap to the full set.
  assign w_upper = i_req & w_at_or_above;
  assign w_pool  = (|w_upper) ? w_upper : i_req;
  assign o_grant = w_pool & (~w_pool + NUM_PORTS'(1));

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter for one router output: picks a head flit by starvation,
// then QoS, then round-robin, holds the lock until the tail and muxes the flit out.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int FLIT_W    = NOC_FLIT_W,
  parameter int AGE_MAX   = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*FLIT_W-1:0] flit_in,
  input  logic [NUM_PORTS-1:0]        valid_in,
  input  logic [NUM_PORTS-1:0]        head_in,
  input  logic [NUM_PORTS-1:0]        tail_in,
  input  logic [NUM_PORTS*2-1:0]      qos_in,
  output logic [NUM_PORTS-1:0]        ready_out,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [NUM_PORTS-1:0]        grant_onehot,
  output logic                        busy,
  output logic [31:0]                 packets_granted,
  output logic [31:0]                 starve_grants
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_SAT   = AGE_W'(AGE_MAX);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  arb_state_t           r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [PTR_W-1:0]     r_grant_idx;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [AGE_W-1:0]     r_age [NUM_PORTS];
  logic [31:0]          r_pkts;
  logic [31:0]          r_starve;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_starved;
  logic [NUM_PORTS-1:0] w_top;
  logic [NUM_PORTS-1:0] w_pick_starved;
  logic [NUM_PORTS-1:0] w_pick_top;
  logic [NUM_PORTS-1:0] w_winner;
  logic [NUM_PORTS-1:0] w_served;
  logic [PTR_W-1:0]     w_win_idx;
  qos_level_t           w_qos [NUM_PORTS];
  qos_level_t           w_max_qos;
  logic                 w_locked;
  logic                 w_valid;
  logic                 w_tail;
  logic                 w_xfer;
  logic [FLIT_W-1:0]    w_flit;

  assign w_req = valid_in & head_in;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_qos[gi]     = qos_level_t'(qos_in[gi*2 +: 2]);
    assign w_starved[gi] = w_req[gi] && (r_age[gi] == AGE_SAT);
    assign w_top[gi]     = w_req[gi] && (w_qos[gi] == w_max_qos);
  end

  always_comb begin
    w_max_qos = QOS_LOW;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_req[i] && (w_qos[i] > w_max_qos)) w_max_qos = w_qos[i];
    end
  end

  noc_rr_pick #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_pick_starved (
    .i_req    (w_starved),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_starved)
  );

  noc_rr_pick #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_pick_top (
    .i_req    (w_top),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_top)
  );

  // A starved requester always beats QoS ordering.
  assign w_winner = (|w_starved) ? w_pick_starved : w_pick_top;

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_winner[i]) w_win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    w_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) w_flit = flit_in[i*FLIT_W +: FLIT_W];
    end
  end

  // Reset blanks the datapath in the same cycle so nothing is accepted mid-reset.
  assign w_locked = (r_state == ST_LOCKED) && !rst;
  assign w_valid  = w_locked && |(r_grant & valid_in);
  assign w_tail   = |(r_grant & tail_in);
  assign w_xfer   = w_valid && ready_in;
  assign w_served = (r_state == ST_IDLE) ? w_winner : r_grant;

  assign valid_out       = w_valid;
  assign flit_out        = w_valid ? w_flit : '0;
  assign ready_out       = w_locked ? (r_grant & {NUM_PORTS{ready_in}}) : '0;
  assign grant_onehot    = r_grant;
  assign busy            = (r_state == ST_LOCKED);
  assign packets_granted = r_pkts;
  assign starve_grants   = r_starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_pkts      <= '0;
      r_starve    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state     <= ST_LOCKED;
            r_grant     <= w_winner;
            r_grant_idx <= w_win_idx;
            r_pkts      <= r_pkts + 32'd1;
            if (|w_starved) r_starve <= r_starve + 32'd1;
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_tail) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= (r_grant_idx == LAST_PORT) ? '0 : r_grant_idx + PTR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rst || !w_req[i] || w_served[i]) begin
        r_age[i] <= '0;
      end else if (r_age[i] != AGE_SAT) begin
        r_age[i] <= r_age[i] + AGE_W'(1);
      end
    end
  end

endmodule
